// File: rtl/fsm_self_test_seq.sv
// fsm_self_test_seq
//   Self-test sequencer for the synchronization block. It stands in for the
//   main FSM state output and walks a state code through 0..N_STATES-1, holding
//   each code for a programmable number of cycles, so the state display and
//   readout path can be exercised without the real acquisition machinery.
//   Code meanings: 0=IDLE, 1=FG_WAIT_OPTO, 2=FG_WAIT_OPEN, 3=WAIT_PHASE_FRONT,
//   4=WAIT_PHASE_DELAY, 5=TRIGGER_PROLONG, 6=DETECTOR_BUSY, 7=DETECTOR_WAIT,
//   8=DETECTOR_FINISHED.
//
// Ports
//   clock         in   1        system clock, rising edge
//   reset         in   1        asynchronous, active-high
//   enable        in   1        1 = run the sequence, 0 = abort / idle
//   mode_loop     in   1        1 = wrap to code 0 after the last code
//   step_mode     in   1        1 = hold at the end of each dwell until step
//   step          in   1        single-cycle pulse, advances one code in hold
//   dwell_cycles  in   DWELL_W  cycles per code, 0 behaves as 1
//   state_out     out  STATE_W  current sequenced code
//   state_change  out  1        pulse on every code entry
//   wrap          out  1        pulse when the last code wraps to code 0
//   busy          out  1        sequence active (RUN or HOLD)
//   done          out  1        single pass completed
//   pass_count    out  PASS_W   completed loop passes, modulo 2**PASS_W

module fsm_self_test_seq #(
  parameter int STATE_W  = 8,
  parameter int N_STATES = 9,
  parameter int DWELL_W  = 24,
  parameter int PASS_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode_loop,
  input  logic               step_mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [STATE_W-1:0] state_out,
  output logic               state_change,
  output logic               wrap,
  output logic               busy,
  output logic               done,
  output logic [PASS_W-1:0]  pass_count
);

  typedef enum logic [1:0] {
    CTRL_OFF,
    CTRL_RUN,
    CTRL_HOLD,
    CTRL_DONE
  } ctrl_e;

  localparam logic [STATE_W-1:0] LAST_CODE = STATE_W'(N_STATES - 1);

  ctrl_e              ctrl_q, ctrl_d;
  logic [STATE_W-1:0] code_q, code_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               change_q, change_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PASS_W-1:0]  pass_q, pass_d;

  logic [DWELL_W-1:0] dwell_load;
  logic               do_advance;
  logic               do_abort;

  // The counter is loaded with D-1 on code entry, so a code is visible for
  // exactly D cycles. A programmed dwell of zero is treated as one cycle.
  always_comb begin
    if (dwell_cycles == '0) begin
      dwell_load = '0;
    end else begin
      dwell_load = dwell_cycles - DWELL_W'(1);
    end
  end

  // Next-state logic. The case statement only decides whether the sequence
  // starts, counts, holds, advances or aborts; the advance and abort effects
  // are applied afterwards so RUN and HOLD share one advance path.
  always_comb begin
    ctrl_d     = ctrl_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    change_d   = 1'b0;
    wrap_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    do_advance = 1'b0;
    do_abort   = 1'b0;

    case (ctrl_q)
      CTRL_OFF: begin
        if (enable) begin
          ctrl_d   = CTRL_RUN;
          code_d   = '0;
          cnt_d    = dwell_load;
          change_d = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = '0;
        end
      end

      // step is deliberately ignored here; it only matters in HOLD.
      CTRL_RUN: begin
        if (!enable) begin
          do_abort = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (step_mode) begin
          ctrl_d = CTRL_HOLD;
        end else begin
          do_advance = 1'b1;
        end
      end

      // Leaving step mode while held releases the hold on the next edge.
      CTRL_HOLD: begin
        if (!enable) begin
          do_abort = 1'b1;
        end else if (step || !step_mode) begin
          do_advance = 1'b1;
        end
      end

      CTRL_DONE: begin
        if (!enable) begin
          do_abort = 1'b1;
        end
      end

      default: begin
        do_abort = 1'b1;
      end
    endcase

    // mode_loop is only looked at here, at the last-code decision.
    if (do_advance) begin
      if (code_q != LAST_CODE) begin
        ctrl_d   = CTRL_RUN;
        code_d   = code_q + STATE_W'(1);
        cnt_d    = dwell_load;
        change_d = 1'b1;
      end else if (mode_loop) begin
        ctrl_d   = CTRL_RUN;
        code_d   = '0;
        cnt_d    = dwell_load;
        change_d = 1'b1;
        wrap_d   = 1'b1;
        pass_d   = pass_q + PASS_W'(1);
      end else begin
        ctrl_d = CTRL_DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end

    // Abort leaves pass_count untouched so it can still be read back.
    if (do_abort) begin
      ctrl_d = CTRL_OFF;
      code_d = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_OFF;
      code_q   <= '0;
      cnt_q    <= '0;
      change_q <= 1'b0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign state_out    = code_q;
  assign state_change = change_q;
  assign wrap         = wrap_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_count   = pass_q;

endmodule

// File: tb/tb_fsm_self_test_seq.sv
// tb_fsm_self_test_seq
//   Randomized self-checking bench for fsm_self_test_seq. Expected outputs
//   come from closed-form arithmetic on the elapsed cycle count since start
//   (code = k/D mod N, pass = k/(N*D), ...) plus directed step-mode, dwell
//   change, abort and asynchronous reset scenarios.

module tb_fsm_self_test_seq;

  localparam int N = 9;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        mode_loop;
  logic        step_mode;
  logic        step;
  logic [23:0] dwell_cycles;
  logic [7:0]  state_out;
  logic        state_change;
  logic        wrap;
  logic        busy;
  logic        done;
  logic [15:0] pass_count;

  int checkCount;
  int errorCount;

  fsm_self_test_seq dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mode_loop    (mode_loop),
    .step_mode    (step_mode),
    .step         (step),
    .dwell_cycles (dwell_cycles),
    .state_out    (state_out),
    .state_change (state_change),
    .wrap         (wrap),
    .busy         (busy),
    .done         (done),
    .pass_count   (pass_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag, input int expPass);
    checkOutput({tag, ".state"}, state_out, 0);
    checkOutput({tag, ".change"}, state_change, 0);
    checkOutput({tag, ".wrap"}, wrap, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".pass"}, pass_count, expPass);
  endtask

  // Reference for a free-running sequence, k cycles after the start edge.
  task automatic checkFree(input int k, input int dEff, input bit loopMode);
    int passLen = N * dEff;
    int expCode, expPass;
    bit expChange, expWrap, expBusy, expDone;
    if (!loopMode && k >= passLen) begin
      expCode = N - 1; expChange = 0; expWrap = 0;
      expBusy = 0; expDone = 1; expPass = 0;
    end else begin
      expCode   = (k / dEff) % N;
      expChange = (k % dEff) == 0;
      expWrap   = loopMode && (k > 0) && ((k % passLen) == 0);
      expBusy   = 1;
      expDone   = 0;
      expPass   = loopMode ? ((k / passLen) % 65536) : 0;
    end
    checkOutput("free.state", state_out, expCode);
    checkOutput("free.change", state_change, expChange);
    checkOutput("free.wrap", wrap, expWrap);
    checkOutput("free.busy", busy, expBusy);
    checkOutput("free.done", done, expDone);
    checkOutput("free.pass", pass_count, expPass);
  endtask

  // Free run of len cycles with random (ignored) step noise, then abort.
  task automatic applyStimulus(input int dwell, input bit loopMode, input int len);
    int dEff = (dwell == 0) ? 1 : dwell;
    int endPass;
    dwell_cycles = 24'(dwell);
    mode_loop    = loopMode;
    step_mode    = 1'b0;
    enable       = 1'b1;
    for (int k = 0; k <= len; k++) begin
      tick();
      checkFree(k, dEff, loopMode);
      step = 1'($urandom_range(0, 1));
    end
    endPass = loopMode ? (len / (N * dEff)) : 0;
    enable = 1'b0;
    step   = 1'b0;
    tick();
    checkIdle("abort", endPass);
    tick();
    checkIdle("off", endPass);
  endtask

  // Step mode: each code dwells D cycles, then holds until a step pulse.
  task automatic stepRun(input int dwell);
    dwell_cycles = 24'(dwell);
    mode_loop    = 1'b0;
    step_mode    = 1'b1;
    enable       = 1'b1;
    tick();
    checkOutput("step.entry", state_out, 0);
    checkOutput("step.entryChange", state_change, 1);
    for (int c = 0; c <= 5; c++) begin
      for (int j = 1; j <= dwell; j++) begin
        step = 1'($urandom_range(0, 1));
        tick();
        checkOutput("step.runState", state_out, c);
        checkOutput("step.runChange", state_change, 0);
        checkOutput("step.runBusy", busy, 1);
      end
      step = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkOutput("step.holdState", state_out, c);
        checkOutput("step.holdChange", state_change, 0);
        checkOutput("step.holdBusy", busy, 1);
      end
      if (c == 5) begin
        step   = 1'b1;
        enable = 1'b0;
        tick();
        step = 1'b0;
        checkIdle("step.abortWins", 0);
      end else if (c == 2) begin
        step_mode = 1'b0;
        tick();
        step_mode = 1'b1;
        checkOutput("step.releaseState", state_out, c + 1);
        checkOutput("step.releaseChange", state_change, 1);
      end else begin
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("step.advState", state_out, c + 1);
        checkOutput("step.advChange", state_change, 1);
      end
    end
    step_mode = 1'b0;
    tick();
    checkIdle("step.off", 0);
  endtask

  // dwell_cycles changes mid code 2: code 2 keeps 4, code 3 lasts 10.
  task automatic dwellChangeRun();
    int expCode;
    dwell_cycles = 24'd4;
    mode_loop    = 1'b0;
    step_mode    = 1'b0;
    enable       = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      tick();
      expCode = (k < 12) ? (k / 4) : ((k < 22) ? 3 : 4);
      checkOutput("dwell.state", state_out, expCode);
      checkOutput("dwell.change", state_change,
                  (k == 0 || k == 4 || k == 8 || k == 12 || k == 22) ? 1 : 0);
      if (k == 9) dwell_cycles = 24'd10;
    end
    enable = 1'b0;
    tick();
    checkIdle("dwell.abort", 0);
  endtask

  // Asynchronous reset between edges clears outputs without a clock.
  task automatic resetMidRun();
    dwell_cycles = 24'd2;
    mode_loop    = 1'b1;
    step_mode    = 1'b0;
    enable       = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checkFree(k, 2, 1'b1);
    end
    #2 reset = 1'b1;
    #1;
    checkIdle("asyncReset", 0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checkIdle("afterReset", 0);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    mode_loop    = 1'b0;
    step_mode    = 1'b0;
    step         = 1'b0;
    dwell_cycles = '0;
    repeat (2) @(posedge clock);
    #1;
    checkIdle("reset", 0);
    reset = 1'b0;
    tick();
    checkIdle("idle", 0);

    applyStimulus(4, 1'b0, 40);
    applyStimulus(2, 1'b1, 60);
    applyStimulus(0, 1'b0, 12);
    applyStimulus(3, 1'b0, 16);
    stepRun(3);
    dwellChangeRun();
    resetMidRun();

    for (int r = 0; r < 8; r++) begin
      int d = $urandom_range(0, 5);
      int dEff = (d == 0) ? 1 : d;
      applyStimulus(d, 1'($urandom_range(0, 1)), $urandom_range(1, 3 * N * dEff + 3));
    end
    stepRun($urandom_range(1, 4));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
